// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared beep FSM state encoding and default pattern timing
package alarm_pkg;

    // FSM state encoding; 2'b11 is unused and recovers to IDLE
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ON   = 2'b01,
        OFF  = 2'b10
    } beep_state_t;

    // Default pattern timing, also used by the top-level alarm instantiation
    localparam int DEF_ON_CYCLES  = 50;
    localparam int DEF_OFF_CYCLES = 50;
    localparam int DEF_BEEPS      = 3;
    localparam int DEF_CNT_W      = 16;
    localparam int DEF_NUM_W      = 4;

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - loadable down-counter that flags the last cycle of a phase
module phase_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Load takes priority; otherwise count down and hold at 1 so it never wraps
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q > CNT_W'(1)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Counter register, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == CNT_W'(1));

endmodule

// File: rtl/beep_pattern_gen.sv
// rtl/beep_pattern_gen.sv - turns a trigger strobe into a timed multi-beep waveform (option: BEEP_RETRIGGER_EN)
module beep_pattern_gen
    import alarm_pkg::*;
#(
    parameter int ON_CYCLES  = DEF_ON_CYCLES,
    parameter int OFF_CYCLES = DEF_OFF_CYCLES,
    parameter int BEEPS      = DEF_BEEPS,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int NUM_W      = DEF_NUM_W
) (
    input  logic clk,
    input  logic reset,
    input  logic trigger,
    input  logic stop,
    output logic beep_out,
    output logic busy,
    output logic done
);

    localparam logic [CNT_W-1:0] ON_VAL  = CNT_W'(ON_CYCLES);
    localparam logic [CNT_W-1:0] OFF_VAL = CNT_W'(OFF_CYCLES);
    localparam logic [NUM_W-1:0] BEEP_N  = NUM_W'(BEEPS);

    beep_state_t      state_q, state_d;
    logic [NUM_W-1:0] beep_cnt_q, beep_cnt_d;
    logic             beep_out_q, beep_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_expire;

    phase_timer #(.CNT_W(CNT_W)) u_phase_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    // Next-state logic: stop beats any retrigger, which beats the phase-end transition
    always_comb begin
        state_d    = state_q;
        beep_cnt_d = beep_cnt_q;
        tmr_load   = 1'b0;
        tmr_val    = ON_VAL;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (trigger && !stop) begin
                    state_d    = ON;
                    beep_cnt_d = NUM_W'(1);
                    tmr_load   = 1'b1;
                end
            end
            ON, OFF: begin
                if (stop) begin
                    state_d    = IDLE;
                    beep_cnt_d = '0;
`ifdef BEEP_RETRIGGER_EN
                end else if (trigger) begin
                    state_d    = ON;
                    beep_cnt_d = NUM_W'(1);
                    tmr_load   = 1'b1;
`endif
                end else if (tmr_expire) begin
                    if (state_q == OFF) begin
                        state_d    = ON;
                        beep_cnt_d = beep_cnt_q + NUM_W'(1);
                        tmr_load   = 1'b1;
                    end else if (beep_cnt_q < BEEP_N) begin
                        state_d  = OFF;
                        tmr_load = 1'b1;
                        tmr_val  = OFF_VAL;
                    end else begin
                        state_d    = IDLE;
                        beep_cnt_d = '0;
                        done_d     = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                beep_cnt_d = '0;
            end
        endcase
        beep_out_d = (state_d == ON);
        busy_d     = (state_d != IDLE);
    end

    // FSM state, beep counter and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            beep_cnt_q <= '0;
            beep_out_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beep_cnt_q <= beep_cnt_d;
            beep_out_q <= beep_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign beep_out = beep_out_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_beep_pattern_gen.sv
// tb/tb_beep_pattern_gen.sv - self-checking bench for beep_pattern_gen (ON=3, OFF=2, BEEPS=2)
module tb_beep_pattern_gen;

    localparam int ON_C    = 3;
    localparam int OFF_C   = 2;
    localparam int NBEEP   = 2;
    localparam int SEQ_LEN = NBEEP * ON_C + (NBEEP - 1) * OFF_C;
`ifdef BEEP_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic trigger;
    logic stop;
    logic beep_out;
    logic busy;
    logic done;

    int checks   = 0;
    int failures = 0;

    // Reference: position of the current cycle within the sequence, -1 when idle
    int m_pos  = -1;
    bit m_done = 1'b0;

    typedef struct {
        logic trig;
        logic stp;
        logic beep;
        logic bsy;
        logic dn;
    } vec_t;
    vec_t vecs[$];

    beep_pattern_gen #(
        .ON_CYCLES  (ON_C),
        .OFF_CYCLES (OFF_C),
        .BEEPS      (NBEEP),
        .CNT_W      (8),
        .NUM_W      (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .trigger  (trigger),
        .stop     (stop),
        .beep_out (beep_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Drive inputs, take one edge, advance the reference, sample 1 time unit later
    task automatic apply(input logic t, input logic s);
        trigger = t;
        stop    = s;
        @(posedge clk);
        if (s && m_pos >= 0) begin
            m_pos  = -1;
            m_done = 1'b0;
        end else if (t && !s && (m_pos < 0 || RETRIG)) begin
            m_pos  = 0;
            m_done = 1'b0;
        end else if (m_pos >= 0) begin
            m_pos++;
            m_done = (m_pos == SEQ_LEN);
            if (m_done) m_pos = -1;
        end else begin
            m_done = 1'b0;
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_beep"}, beep_out, (m_pos >= 0) && ((m_pos % (ON_C + OFF_C)) < ON_C));
        check({tag, "_busy"}, busy, m_pos >= 0);
        check({tag, "_done"}, done, m_done);
    endtask

    task automatic add(input logic t, input logic s, input logic b, input logic bu, input logic d,
                       input int n);
        for (int i = 0; i < n; i++) begin
            vec_t v;
            v.trig = t; v.stp = s; v.beep = b; v.bsy = bu; v.dn = d;
            vecs.push_back(v);
        end
    endtask

    // Scenario 2 waveform following a trigger row
    task automatic add_basic_seq();
        add(1, 0, 1, 1, 0, 1);
        add(0, 0, 1, 1, 0, 2);
        add(0, 0, 0, 1, 0, 2);
        add(0, 0, 1, 1, 0, 3);
        add(0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 2);
    endtask

    initial begin
        reset   = 1'b1;
        trigger = 1'b0;
        stop    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_beep", beep_out, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        reset = 1'b0;

        // Idle, basic sequence, stop in OFF, second trigger, trigger+stop in IDLE
        add(0, 0, 0, 0, 0, 20);
        add_basic_seq();
        add(1, 0, 1, 1, 0, 1);
        add(0, 0, 1, 1, 0, 2);
        add(0, 0, 0, 1, 0, 1);
        add(0, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 5);
        add(1, 0, 1, 1, 0, 1);
        add(0, 0, 1, 1, 0, 2);
`ifdef BEEP_RETRIGGER_EN
        add(1, 0, 1, 1, 0, 1);
        add(0, 0, 1, 1, 0, 2);
        add(0, 0, 0, 1, 0, 2);
        add(0, 0, 1, 1, 0, 3);
        add(0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 1);
`else
        add(1, 0, 0, 1, 0, 1);
        add(0, 0, 0, 1, 0, 1);
        add(0, 0, 1, 1, 0, 3);
        add(0, 0, 0, 0, 1, 1);
        add(0, 0, 0, 0, 0, 4);
`endif
        add(1, 1, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 3);

        foreach (vecs[i]) begin
            apply(vecs[i].trig, vecs[i].stp);
            check("vec_beep", beep_out, vecs[i].beep);
            check("vec_busy", busy, vecs[i].bsy);
            check("vec_done", done, vecs[i].dn);
        end

        // Asynchronous reset in the middle of an ON phase
        apply(1, 0);
        apply(0, 0);
        #2 reset = 1'b1;
        #1;
        check("async_rst_beep", beep_out, 1'b0);
        check("async_rst_busy", busy, 1'b0);
        m_pos  = -1;
        m_done = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            apply(0, 0);
            check_model("post_rst_idle");
        end
        apply(1, 0);
        check_model("post_rst_seq");
        for (int i = 0; i < 10; i++) begin
            apply(0, 0);
            check_model("post_rst_seq");
        end

        // Randomized triggers and stops against the reference
        for (int i = 0; i < 1500; i++) begin
            apply($urandom_range(0, 7) == 0, $urandom_range(0, 24) == 0);
            check_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
